// File: rtl/store_unit_if.sv
// Bundles the MEM-stage store port and the data-memory write port of store_unit.
// The slave side is the store unit; the master side is the core plus memory.
interface store_unit_if #(
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             st_valid;
    logic [1:0]       st_type;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic             st_ready;
    logic             st_misalign;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_ack;
    logic [CNT_W-1:0] buf_count;
    logic             buf_empty;

    modport master (
        output st_valid, st_type, st_addr, st_data, mem_ack,
        input  st_ready, st_misalign, mem_req, mem_addr, mem_wdata, mem_wstrb,
               buf_count, buf_empty
    );

    modport slave (
        input  st_valid, st_type, st_addr, st_data, mem_ack,
        output st_ready, st_misalign, mem_req, mem_addr, mem_wdata, mem_wstrb,
               buf_count, buf_empty
    );
endinterface

// File: rtl/store_unit.sv
// Formats SB/SH/SW stores into word-aligned data plus byte strobes, queues them
// in a small FIFO store buffer and drains them to memory over req/ack.
module store_unit #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    store_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    logic [CNT_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] rd_ptr_reg;
    logic [29:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [3:0]       strb_mem [DEPTH];

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             full;
    logic             empty;
    logic             bad_align;
    logic [31:0]      fmt_wdata;
    logic [3:0]       fmt_strb;
    logic             push;
    logic             pop;

    assign wr_idx = wr_ptr_reg[IDX_W-1:0];
    assign rd_idx = rd_ptr_reg[IDX_W-1:0];
    assign full   = (wr_ptr_reg[CNT_W-1] != rd_ptr_reg[CNT_W-1]) && (wr_idx == rd_idx);
    assign empty  = (wr_ptr_reg == rd_ptr_reg);

    always_comb begin
        fmt_wdata = bus.st_data;
        fmt_strb  = 4'b1111;
        bad_align = 1'b0;
        case (bus.st_type)
            2'b00: begin
                fmt_wdata = {4{bus.st_data[7:0]}};
                fmt_strb  = 4'b0001 << bus.st_addr[1:0];
            end
            2'b01: begin
                fmt_wdata = {2{bus.st_data[15:0]}};
                fmt_strb  = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                bad_align = bus.st_addr[0];
            end
            2'b10:   bad_align = (bus.st_addr[1:0] != 2'b00);
            default: bad_align = 1'b1;
        endcase
    end

    assign bus.st_misalign = bus.st_valid && bad_align;
    assign bus.st_ready    = !full;
    // full comes from registered pointers, so a same-cycle pop never frees a slot early
    assign push = bus.st_valid && !full && !bad_align;
    assign pop  = !empty && bus.mem_ack;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_idx == IDX_W'(gi))) begin
                    addr_mem[gi] <= bus.st_addr[31:2];
                    data_mem[gi] <= fmt_wdata;
                    strb_mem[gi] <= fmt_strb;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign bus.mem_req   = !empty;
    assign bus.mem_addr  = empty ? 32'h0 : {addr_mem[rd_idx], 2'b00};
    assign bus.mem_wdata = empty ? 32'h0 : data_mem[rd_idx];
    assign bus.mem_wstrb = empty ? 4'h0  : strb_mem[rd_idx];
    assign bus.buf_count = wr_ptr_reg - rd_ptr_reg;
    assign bus.buf_empty = empty;
endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: vector table, hand-written corner
// sequences and random traffic against a queue-based reference model.
module tb_store_unit;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } wr_t;

    typedef struct {
        logic [1:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        logic        mis;
        logic [31:0] ea;
        logic [31:0] ew;
        logic [3:0]  es;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    wr_t  mq[$];
    vec_t tbl[8];

    store_unit_if #(.DEPTH(DEPTH)) bus ();

    store_unit #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic ref_mis(input logic [1:0] t, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (t == 2'd3) return 1'b1;
        if (t == 2'd1) return (off % 2) != 0;
        if (t == 2'd2) return off != 0;
        return 1'b0;
    endfunction

    // Per-lane view: which byte of the source each lane carries, and whether it is enabled
    function automatic void ref_fmt(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                                    output logic [31:0] w, output logic [3:0] s);
        int off;
        off = int'(a[1:0]);
        for (int lane = 0; lane < 4; lane++) begin
            if (t == 2'd0) begin
                w[8*lane +: 8] = d[7:0];
                s[lane]        = (lane == off);
            end else if (t == 2'd1) begin
                w[8*lane +: 8] = d[8*(lane%2) +: 8];
                s[lane]        = (lane / 2) == (off / 2);
            end else begin
                w[8*lane +: 8] = d[8*lane +: 8];
                s[lane]        = 1'b1;
            end
        end
    endfunction

    task automatic step(input logic v, input logic [1:0] t, input logic [31:0] a,
                        input logic [31:0] d, input logic k);
        logic        e_mis;
        logic [31:0] ew;
        logic [3:0]  es;
        int          n;
        wr_t         e;
        @(negedge clk);
        bus.st_valid = v;
        bus.st_type  = t;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.mem_ack  = k;
        #1;
        e_mis = v && ref_mis(t, a);
        ref_fmt(t, a, d, ew, es);
        n = mq.size();
        chk("st_ready",    32'(bus.st_ready),    32'(n < DEPTH));
        chk("st_misalign", 32'(bus.st_misalign), 32'(e_mis));
        chk("mem_req",     32'(bus.mem_req),     32'(n != 0));
        chk("buf_count",   32'(bus.buf_count),   32'(n));
        chk("buf_empty",   32'(bus.buf_empty),   32'(n == 0));
        if (n != 0) begin
            chk("mem_addr",  bus.mem_addr,        mq[0].addr);
            chk("mem_wdata", bus.mem_wdata,       mq[0].wdata);
            chk("mem_wstrb", 32'(bus.mem_wstrb),  32'(mq[0].strb));
        end else begin
            chk("mem_addr_idle",  bus.mem_addr,       32'h0);
            chk("mem_wdata_idle", bus.mem_wdata,      32'h0);
            chk("mem_wstrb_idle", 32'(bus.mem_wstrb), 32'h0);
        end
        if (n != 0 && k) begin
            e = mq.pop_front();
            $display("write addr=%h data=%h strb=%b", e.addr, e.wdata, e.strb);
        end
        if (v && n < DEPTH && !e_mis) begin
            e.addr  = {a[31:2], 2'b00};
            e.wdata = ew;
            e.strb  = es;
            mq.push_back(e);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_type  = 2'd0;
        bus.st_addr  = 32'h0;
        bus.st_data  = 32'h0;
        bus.mem_ack  = 1'b0;

        tbl[0] = '{2'd0, 32'h0000_1003, 32'h0000_00A5, 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000};
        tbl[1] = '{2'd1, 32'h0000_2002, 32'h1234_BEEF, 1'b0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
        tbl[2] = '{2'd2, 32'h0000_2004, 32'hCAFE_F00D, 1'b0, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111};
        tbl[3] = '{2'd1, 32'h0000_0011, 32'h1111_1111, 1'b1, 32'h0, 32'h0, 4'b0000};
        tbl[4] = '{2'd2, 32'h0000_0012, 32'h2222_2222, 1'b1, 32'h0, 32'h0, 4'b0000};
        tbl[5] = '{2'd3, 32'h0000_0040, 32'h3333_3333, 1'b1, 32'h0, 32'h0, 4'b0000};
        tbl[6] = '{2'd0, 32'h0000_3000, 32'h1234_567E, 1'b0, 32'h0000_3000, 32'h7E7E_7E7E, 4'b0001};
        tbl[7] = '{2'd1, 32'h0000_3000, 32'hFFFF_5A5A, 1'b0, 32'h0000_3000, 32'h5A5A_5A5A, 4'b0011};

        // Reset state, observed mid-cycle while reset is held
        #3;
        chk("rst_st_ready",  32'(bus.st_ready),  32'h1);
        chk("rst_mem_req",   32'(bus.mem_req),   32'h0);
        chk("rst_buf_count", 32'(bus.buf_count), 32'h0);
        chk("rst_buf_empty", 32'(bus.buf_empty), 32'h1);
        chk("rst_mem_addr",  bus.mem_addr,       32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table: issue with ack low, then inspect head and drain it
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].t, tbl[i].a, tbl[i].d, 1'b0);
            chk("tbl_misalign", 32'(bus.st_misalign), 32'(tbl[i].mis));
            step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
            chk("tbl_req", 32'(bus.mem_req), 32'(!tbl[i].mis));
            if (!tbl[i].mis) begin
                chk("tbl_addr",  bus.mem_addr,       tbl[i].ea);
                chk("tbl_wdata", bus.mem_wdata,      tbl[i].ew);
                chk("tbl_wstrb", 32'(bus.mem_wstrb), 32'(tbl[i].es));
            end else begin
                chk("tbl_count", 32'(bus.buf_count), 32'h0);
            end
        end
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);

        // Full buffer: third store stalls, one ack frees a slot the following cycle
        step(1'b1, 2'd2, 32'h0000_0100, 32'hAAAA_0001, 1'b0);
        step(1'b1, 2'd2, 32'h0000_0104, 32'hAAAA_0002, 1'b0);
        step(1'b1, 2'd2, 32'h0000_0108, 32'hAAAA_0003, 1'b0);
        chk("full_ready", 32'(bus.st_ready), 32'h0);
        chk("full_hold",  bus.mem_addr,      32'h0000_0100);
        step(1'b1, 2'd2, 32'h0000_0108, 32'hAAAA_0003, 1'b0);
        chk("full_hold2", bus.mem_wdata,     32'hAAAA_0001);
        step(1'b1, 2'd2, 32'h0000_0108, 32'hAAAA_0003, 1'b1);
        chk("full_pop_ready", 32'(bus.st_ready), 32'h0);
        step(1'b1, 2'd2, 32'h0000_0108, 32'hAAAA_0003, 1'b0);
        chk("after_pop_ready", 32'(bus.st_ready), 32'h1);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);

        // Streaming with ack held high across pointer wrap
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 2'd2, 32'h0000_4000 + 32'(4 * i), $urandom, 1'b1);
            if (i > 0) chk("stream_count", 32'(bus.buf_count), 32'h1);
        end
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);

        // Asynchronous reset with two entries held
        step(1'b1, 2'd2, 32'h0000_0500, 32'h5555_0001, 1'b0);
        step(1'b1, 2'd2, 32'h0000_0504, 32'h5555_0002, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_rst_count", 32'(bus.buf_count), 32'h2);
        bus.st_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_mem_req",   32'(bus.mem_req),   32'h0);
        chk("arst_buf_count", 32'(bus.buf_count), 32'h0);
        chk("arst_st_ready",  32'(bus.st_ready),  32'h1);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), ra, $urandom,
                 $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
